// File: rtl/mix_bias_seq.sv
// rtl/mix_bias_seq.sv - mix-layer bias ROM read sequencer with credit-controlled output FIFO
module mix_bias_seq #(
    parameter int N_LEN      = 8,
    parameter int HID_DIM    = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       layer,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [N_LEN-1:0] rom_addr,
    input  logic [N_LEN-1:0] rom_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_LEN-1:0] out_data,
    output logic [N_LEN-1:0] out_idx,
    output logic             out_last
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [N_LEN-1:0] HID_N    = N_LEN'(HID_DIM);
    localparam logic [N_LEN-1:0] LAST_IDX = N_LEN'(HID_DIM - 1);
    localparam logic [CW:0]      DEPTH_C  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [PW-1:0]    PTR_MAX  = PW'(FIFO_DEPTH - 1);

    generate
        if (3 * HID_DIM - 1 >= (1 << N_LEN)) begin : g_addr_chk
            $error("mix_bias_seq: 3*HID_DIM-1 does not fit in N_LEN bits");
        end
        if (FIFO_DEPTH < 3) begin : g_depth_chk
            $error("mix_bias_seq: FIFO_DEPTH must be at least 3");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N_LEN-1:0] base_q, idx_q, rom_addr_q;
    logic [CW-1:0]    inflight_q, cnt_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             s1_v_q, s2_v_q;
    logic [N_LEN-1:0] s1_idx_q, s2_idx_q;
    logic             done_q, err_q;

    logic [N_LEN-1:0] fifo_data [FIFO_DEPTH];
    logic [N_LEN-1:0] fifo_idx  [FIFO_DEPTH];
    logic             fifo_last [FIFO_DEPTH];

    logic [N_LEN-1:0] layer_base, issue_addr, issue_idx;
    logic             start_ok, start_bad, issue, credit_ok;
    logic             push, pop, fifo_empty, drain_done;

    always_comb begin
        layer_base = '0;
        case (layer)
            2'd1:    layer_base = HID_N;
            2'd2:    layer_base = N_LEN'(2 * HID_DIM);
            default: layer_base = '0;
        endcase
    end

    assign credit_ok  = ({1'b0, cnt_q} + {1'b0, inflight_q}) < DEPTH_C;
    assign fifo_empty = (cnt_q == '0);
    assign push       = s2_v_q;
    assign pop        = !fifo_empty && out_ready;
    assign drain_done = pop && fifo_last[rd_ptr_q] && (cnt_q == CW'(1)) && (inflight_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = (HID_DIM == 1) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (idx_q == LAST_IDX)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The accepting cycle itself issues element 0 so rom_addr=base one cycle after start.
    always_comb begin
        start_ok   = 1'b0;
        start_bad  = 1'b0;
        issue      = 1'b0;
        issue_addr = base_q + idx_q;
        issue_idx  = idx_q;
        case (state_q)
            S_IDLE: begin
                start_ok  = start && (layer != 2'd3);
                start_bad = start && (layer == 2'd3);
                if (start_ok) begin
                    issue      = 1'b1;
                    issue_addr = layer_base;
                    issue_idx  = '0;
                end
            end
            S_RUN:   issue = credit_ok && (idx_q < HID_N);
            default: issue = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q     <= '0;
            idx_q      <= '0;
            rom_addr_q <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s1_idx_q   <= '0;
            s2_idx_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (start_ok) begin
                base_q <= layer_base;
            end
            if (issue) begin
                rom_addr_q <= issue_addr;
                idx_q      <= issue_idx + N_LEN'(1);
            end
            // Tag travels alongside the ROM's one-cycle read latency.
            s1_v_q   <= issue;
            s1_idx_q <= issue_idx;
            s2_v_q   <= s1_v_q;
            s2_idx_q <= s1_idx_q;

            case ({issue, push})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
            end

            done_q <= (state_q == S_DRAIN) && (state_d == S_IDLE);
            err_q  <= start_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr_q] <= rom_data;
            fifo_idx[wr_ptr_q]  <= s2_idx_q;
            fifo_last[wr_ptr_q] <= (s2_idx_q == LAST_IDX);
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rom_addr  = rom_addr_q;
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_data[rd_ptr_q];
    assign out_idx   = fifo_empty ? '0 : fifo_idx[rd_ptr_q];
    assign out_last  = fifo_empty ? 1'b0 : fifo_last[rd_ptr_q];

endmodule

// File: tb/tb_mix_bias_seq.sv
// tb/tb_mix_bias_seq.sv - self-checking bench for mix_bias_seq against a queue-based reference
module tb_mix_bias_seq;

    localparam int NL = 8;
    localparam int HD = 24;
    localparam int FD = 4;

    logic          clk, rst_n, start, busy, done, err;
    logic [1:0]    layer;
    logic [NL-1:0] rom_addr, rom_data, out_data, out_idx;
    logic          out_valid, out_ready, out_last;
    logic [NL-1:0] rom [0:3*HD-1];

    int n_checks = 0;
    int n_pass   = 0;

    mix_bias_seq #(.N_LEN(NL), .HID_DIM(HD), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .layer(layer),
        .busy(busy), .done(done), .err(err),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
        check({tag, "_addr"}, rom_addr, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_idx"}, out_idx, 0);
    endtask

    // mode: 0 ready=1, 1 random ready, 2 ready=0 for 20 cycles, 3 re-start while busy, 4 reset after beat 10
    task automatic run_layer(input int lay, input int mode);
        int exp_q[$];
        int beat = 0, dones = 0, errs = 0, cyc = 0, first_valid = -1, post = 0;
        int base, occ, max_occ = 0;
        bit hold_v = 0;
        logic [NL-1:0] hold_d = '0;
        base = lay * HD;
        for (int k = 0; k < HD; k++) exp_q.push_back(base + k + 100);
        start = 1'b1;
        layer = 2'(lay);
        out_ready = (mode == 2) ? 1'b0 : 1'b1;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc < 400 && post < 4) begin
            if (cyc == 1) begin
                check("first_addr", rom_addr, base);
                check("busy_run", busy, 1);
            end
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (hold_v) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_d);
            end
            occ = int'(rom_addr) - base + 1 - beat;
            if (occ > max_occ) max_occ = occ;
            if (done) dones++;
            if (err) errs++;
            if (mode == 2 && cyc == 19) check("bp_addr_stop", rom_addr, base + FD - 1);

            start = 1'b0;
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (cyc >= 20);
                default: out_ready = 1'b1;
            endcase
            if (mode == 3 && cyc == 5) begin
                start = 1'b1;
                layer = 2'd0;
            end
            if (mode == 3 && cyc == 9) begin
                start = 1'b1;
                layer = 2'd3;
            end

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", beat, HD);
                end else begin
                    check("beat_data", out_data, exp_q[0]);
                    check("beat_idx", out_idx, beat);
                    check("beat_last", out_last, (beat == HD - 1));
                    void'(exp_q.pop_front());
                end
                beat++;
                hold_v = 0;
            end else if (out_valid) begin
                hold_v = 1;
                hold_d = out_data;
            end else begin
                hold_v = 0;
            end

            if (mode == 4 && beat == 10) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
                check_idle_outputs("mid_reset");
                for (int j = 0; j < 3; j++) begin
                    step();
                    check("post_reset_valid", out_valid, 0);
                    check("post_reset_busy", busy, 0);
                end
                return;
            end
            if (beat >= HD) post++;
            step();
            cyc++;
        end
        check("beat_count", beat, HD);
        check("done_count", dones, 1);
        check("err_count", errs, 0);
        check("busy_after", busy, 0);
        check("first_valid_cycle", first_valid, 3);
        check("occ_le_depth", (max_occ <= FD), 1);
        if (mode == 2) check("bp_occ_full", max_occ, FD);
    endtask

    task automatic err_test();
        int errs = 0, busys = 0, valids = 0;
        logic [NL-1:0] addr0;
        addr0 = rom_addr;
        start = 1'b1;
        layer = 2'd3;
        step();
        start = 1'b0;
        check("err_pulse", err, 1);
        for (int j = 0; j < 6; j++) begin
            if (err) errs++;
            if (busy) busys++;
            if (out_valid) valids++;
            check("err_addr_hold", rom_addr, addr0);
            step();
        end
        check("err_once", errs, 1);
        check("err_no_busy", busys, 0);
        check("err_no_valid", valids, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        layer = 2'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 3 * HD; i++) rom[i] = NL'(i + 100);
        step();
        step();
        rst_n = 1'b1;
        check_idle_outputs("reset");
        step();

        run_layer(1, 0);
        step();
        run_layer(2, 1);
        step();
        run_layer(0, 2);
        step();
        err_test();
        run_layer(0, 3);
        step();
        run_layer(0, 4);
        step();
        run_layer(0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mix_bias_seq.md
Name: mix_bias_seq

Overview:
- Read sequencer for the mix-layer bias ROM (rom_b_core). The ROM is 3*HID_DIM entries: three layers with HID_DIM biases each.
- On a start command for one layer, it issues HID_DIM consecutive ROM addresses.
- It captures the 1-cycle-latency ROM data into a small credit-controlled FIFO and streams the biases to the mix-layer MAC with valid/ready backpressure.
- It owns the only rom_b_core address port.

Parameters:
- N_LEN, `N_LEN: data width and ROM address width.
- HID_DIM, `HID_DIM: biases per layer.
- FIFO_DEPTH, 4: output buffer entries; must be at least 3.

Ports:
- clk  input  1  clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  command pulse; sampled only when busy=0.
- layer  input  2  layer select 0..2; sampled with start.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last element handshake.
- err  output  1  one-cycle pulse when start is sampled with layer=3.
- rom_addr  output  N_LEN  registered address to rom_b_core.addr.
- rom_data  input  N_LEN  rom_b_core.output_bias; valid one cycle after rom_addr.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_data  output  N_LEN  bias value.
- out_idx  output  N_LEN  element index 0..HID_DIM-1 of out_data.
- out_last  output  1  high with the element whose out_idx=HID_DIM-1.

Behaviour:
- Reset (rst_n=0 at an edge):
  - State goes to IDLE.
  - busy, done, err, out_valid, out_last are 0.
  - rom_addr, out_data, out_idx are 0.
  - FIFO is emptied, in-flight counter cleared, issue index cleared.
  - Reset mid-run aborts the run. A ROM read issued before reset is discarded, never written.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 with layer≤2: base = layer*HID_DIM, issue index = 0, go to RUN, busy=1.
  - start=1 with layer=3: err pulses, state stays IDLE.
- RUN:
  - A read is issued in a cycle iff (fifo_count + inflight) < FIFO_DEPTH and issue index < HID_DIM.
  - Issuing sets rom_addr = base + index at the next edge, increments the index, and increments inflight.
  - When the index reaches HID_DIM, go to DRAIN.
- Capture:
  - rom_data is written to the FIFO, tagged with its index, at the edge two after the issuing cycle; inflight decrements at that edge.
  - Entries are returned strictly in order.
- DRAIN: when the FIFO is empty, inflight=0, and the last element has handshaked, go to IDLE. done pulses in the cycle after that handshake, and busy drops in the same cycle.
- Output:
  - out_valid = FIFO non-empty; out_data, out_idx, out_last come from the FIFO head.
  - A pop occurs on out_valid & out_ready.
  - Head data is held stable while out_ready=0.
- Simultaneous FIFO write and pop in one cycle: both occur and the count is unchanged.
- start while busy=1 is ignored; no err and no state change.
- Latency: start high in cycle 0 → rom_addr=base in cycle 1 → out_valid in cycle 3.
- Throughput: 1 element/cycle sustained while out_ready=1. A full layer takes HID_DIM+3 cycles from start to the last element presented.
- Backpressure never overflows the FIFO: the credit rule guarantees fifo_count ≤ FIFO_DEPTH.
- rom_addr holds its last value when no read is issued.
- Address arithmetic is unsigned, N_LEN bits. 3*HID_DIM-1 must fit in N_LEN bits; this is a static elaboration check.

Test Plan:
- HID_DIM=24, preload ROM mem[k]=k+100, out_ready=1, start with layer=1 at cycle 0:
  - out_valid rises in cycle 3 with out_data=124, out_idx=0.
  - 24 consecutive beats follow, ending with out_data=147 and out_last=1.
  - done pulses once; busy is low afterwards.
- layer=2, out_ready toggling 1,0,0,1,… (random):
  - Sequence is 148..171 in order, no drops or duplicates.
  - fifo_count never exceeds 4.
  - out_data stays stable while out_ready=0.
- out_ready=0 for 20 cycles after start on layer 0:
  - Exactly 4 reads issued; rom_addr stops at 3.
  - Release gives values 100..123 in order.
- start with layer=3:
  - err pulses 1 cycle; busy stays 0; no rom_addr change; no out_valid.
- start pulsed again while busy (layer=0 run):
  - Second start ignored; exactly 24 beats; a single done.
- rst_n low for 1 cycle mid-run (after beat 10):
  - Next cycle all outputs 0 and FIFO empty.
  - A fresh start on layer 0 streams 100..123 with no stale data.
